signed_arith_pipe: RTL and testbench

//   Two-stage pipelined integer ALU with per-operand signedness flags that follow IEEE 1364 expression rules:
//   a mixed signed/unsigned expression is evaluated as unsigned, and >>> fills with the sign bit only for a signed left operand.

---
 rtl/signed_arith_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_signed_arith_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_arith_pipe.sv
// Two-stage pipelined integer ALU with per-operand signedness following Verilog expression rules.
// Stage 1 forms the exact (or range-encoded) result at WIDTH+2 bits; stage 2 checks range and clamps.
module signed_arith_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_a_sgn,
   input  logic             in_b_sgn,
   input  logic             in_sat,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sgn,
   output logic             out_ovf,
   output logic             out_ill,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] ovf_cnt
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned RW  = WIDTH + 2;
   localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_SHL  = 3'd2;
   localparam logic [2:0] OP_LSHR = 3'd3;
   localparam logic [2:0] OP_ASHR = 3'd4;
   localparam logic [2:0] OP_MIX  = 3'd5;

   logic                 w_en;
   logic                 w_sgn;
   logic                 w_ill;
   logic                 w_b_big;
   logic                 w_a_neg;
   logic                 w_shl_ovf;
   logic [SHW-1:0]       w_sh;
   logic [RW-1:0]        w_ea;
   logic [RW-1:0]        w_eb;
   logic [RW-1:0]        w_raw;
   logic [WIDTH-1:0]     w_lo;
   logic [2*WIDTH-1:0]   w_shl_full;

   logic                 r1_valid;
   logic                 r1_sgn;
   logic                 r1_sat;
   logic                 r1_ill;
   logic [RW-1:0]        r1_raw;

   logic [2:0]           w_top;
   logic                 w_ovf;
   logic [WIDTH-1:0]     w_data;

   logic                 r_out_valid;
   logic [WIDTH-1:0]     r_out_data;
   logic                 r_out_sgn;
   logic                 r_out_ovf;
   logic                 r_out_ill;
   logic [CNT_W-1:0]     r_cnt;

   assign w_en     = !r_out_valid || out_ready;
   assign in_ready = w_en;

   // SHL overflow is resolved here and folded into the top two raw bits so that stage 2
   // sees an out-of-range value with the correct sign while the low bits keep the wrap result.
   always_comb begin
      w_sgn      = 1'b0;
      w_ill      = 1'b0;
      w_raw      = '0;
      w_lo       = '0;
      w_shl_ovf  = 1'b0;
      w_b_big    = (in_b >= W_LIM);
      w_sh       = in_b[SHW-1:0];
      w_a_neg    = in_a_sgn && in_a[WIDTH-1];
      w_ea       = (in_a_sgn && in_b_sgn) ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
      w_eb       = (in_a_sgn && in_b_sgn) ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
      w_shl_full = {{WIDTH{w_a_neg}}, in_a} << w_sh;
      case (in_op)
         OP_ADD: begin
            w_sgn = in_a_sgn && in_b_sgn;
            w_raw = w_ea + w_eb;
         end
         OP_SUB: begin
            w_sgn = in_a_sgn && in_b_sgn;
            w_raw = w_ea - w_eb;
         end
         OP_SHL: begin
            w_sgn = in_a_sgn;
            if (w_b_big) begin
               w_lo      = '0;
               w_shl_ovf = |in_a;
            end else begin
               w_lo      = w_shl_full[WIDTH-1:0];
               w_shl_ovf = in_a_sgn ? !((&w_shl_full[2*WIDTH-1:WIDTH-1]) ||
                                        !(|w_shl_full[2*WIDTH-1:WIDTH-1]))
                                    : |w_shl_full[2*WIDTH-1:WIDTH];
            end
            if (w_shl_ovf) begin
               w_raw = {(w_a_neg ? 2'b10 : 2'b01), w_lo};
            end else begin
               w_raw = {{2{in_a_sgn && w_lo[WIDTH-1]}}, w_lo};
            end
         end
         OP_LSHR: begin
            w_sgn = in_a_sgn;
            w_lo  = in_a >> in_b;
            w_raw = {{2{w_sgn && w_lo[WIDTH-1]}}, w_lo};
         end
         OP_ASHR: begin
            w_sgn = in_a_sgn;
            w_lo  = w_a_neg ? ~((~in_a) >> in_b) : (in_a >> in_b);
            w_raw = {{2{w_sgn && w_lo[WIDTH-1]}}, w_lo};
         end
         OP_MIX: begin
            w_lo  = {in_a[WIDTH-1:WIDTH/2], in_b[WIDTH/2-1:0]};
            w_raw = {2'b00, w_lo};
         end
         default: begin
            w_ill = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid <= 1'b0;
         r1_sgn   <= 1'b0;
         r1_sat   <= 1'b0;
         r1_ill   <= 1'b0;
         r1_raw   <= '0;
      end else if (w_en) begin
         r1_valid <= in_valid;
         if (in_valid) begin
            r1_sgn <= w_sgn;
            r1_sat <= in_sat;
            r1_ill <= w_ill;
            r1_raw <= w_raw;
         end
      end
   end

   assign w_top = r1_raw[RW-1:WIDTH-1];

   always_comb begin
      w_ovf  = 1'b0;
      w_data = r1_raw[WIDTH-1:0];
      if (r1_ill) begin
         w_data = '0;
      end else begin
         w_ovf = r1_sgn ? !((&w_top) || !(|w_top)) : |r1_raw[RW-1:WIDTH];
         // The raw sign bit tells which limit is nearest the exact result.
         if (w_ovf && r1_sat) begin
            if (r1_sgn) begin
               w_data = r1_raw[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
               w_data = r1_raw[RW-1] ? '0 : '1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sgn   <= 1'b0;
         r_out_ovf   <= 1'b0;
         r_out_ill   <= 1'b0;
      end else if (w_en) begin
         r_out_valid <= r1_valid;
         if (r1_valid) begin
            r_out_data <= w_data;
            r_out_sgn  <= r1_sgn;
            r_out_ovf  <= w_ovf;
            r_out_ill  <= r1_ill;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= '0;
      end else if (r_out_valid && out_ready && r_out_ovf && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sgn   = r_out_sgn;
   assign out_ovf   = r_out_ovf;
   assign out_ill   = r_out_ill;
   assign ovf_cnt   = r_cnt;

endmodule

// File: tb/tb_signed_arith_pipe.sv
// Directed bench for signed_arith_pipe (WIDTH=8, CNT_W=2) with hand-computed expectations.
module tb_signed_arith_pipe;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic       in_a_sgn;
   logic       in_b_sgn;
   logic       in_sat;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_sgn;
   logic       out_ovf;
   logic       out_ill;
   logic       cnt_clr;
   logic [1:0] ovf_cnt;

   int total;
   int bad;

   signed_arith_pipe #(
      .WIDTH (8),
      .CNT_W (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a_sgn  (in_a_sgn),
      .in_b_sgn  (in_b_sgn),
      .in_sat    (in_sat),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sgn   (out_sgn),
      .out_ovf   (out_ovf),
      .out_ill   (out_ill),
      .cnt_clr   (cnt_clr),
      .ovf_cnt   (ovf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic as, input logic bs, input logic sat,
                        input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      in_op    = op;
      in_a_sgn = as;
      in_b_sgn = bs;
      in_sat   = sat;
      in_a     = a;
      in_b     = b;
   endtask

   // Called #1 after a clock edge with an empty output stage; ends #1 after the consuming edge.
   task automatic run_op(input string tag, input logic [2:0] op, input logic as, input logic bs,
                         input logic sat, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic es, input logic eo, input logic ei);
      out_ready = 1'b1;
      drive(op, as, bs, sat, a, b);
      chk({tag, ".rdy"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, ".early"}, out_valid, 0);
      @(posedge clk); #1;
      chk({tag, ".vld"}, out_valid, 1);
      chk({tag, ".data"}, out_data, ed);
      chk({tag, ".sgn"}, out_sgn, es);
      chk({tag, ".ovf"}, out_ovf, eo);
      chk({tag, ".ill"}, out_ill, ei);
      @(posedge clk); #1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      drive(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      in_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.vld", out_valid, 0);
      chk("rst.data", out_data, 8'h00);
      chk("rst.ovf", out_ovf, 0);
      chk("rst.ill", out_ill, 0);
      chk("rst.sgn", out_sgn, 0);
      chk("rst.cnt", ovf_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ADD/SUB signedness and saturation
      run_op("add_ss_wrap", 3'd0, 1, 1, 0, 8'h7F, 8'h01, 8'h80, 1, 1, 0);
      run_op("add_ss_sat",  3'd0, 1, 1, 1, 8'h7F, 8'h01, 8'h7F, 1, 1, 0);
      run_op("add_mixed",   3'd0, 1, 0, 0, 8'hFF, 8'h01, 8'h00, 0, 1, 0);
      run_op("sub_uu_sat",  3'd1, 0, 0, 1, 8'h00, 8'h01, 8'h00, 0, 1, 0);
      run_op("add_ss_neg",  3'd0, 1, 1, 1, 8'h80, 8'hFF, 8'h80, 1, 1, 0);
      // Shifts
      run_op("ashr_s3",     3'd4, 1, 0, 0, 8'h80, 8'h03, 8'hF0, 1, 0, 0);
      run_op("ashr_u3",     3'd4, 0, 0, 0, 8'h80, 8'h03, 8'h10, 0, 0, 0);
      run_op("ashr_s9",     3'd4, 1, 0, 0, 8'h80, 8'h09, 8'hFF, 1, 0, 0);
      run_op("ashr_u9",     3'd4, 0, 0, 0, 8'h80, 8'h09, 8'h00, 0, 0, 0);
      run_op("lshr_s3",     3'd3, 1, 1, 0, 8'h80, 8'h03, 8'h10, 1, 0, 0);
      run_op("shl_s40",     3'd2, 1, 0, 0, 8'h40, 8'h01, 8'h80, 1, 1, 0);
      run_op("shl_sneg",    3'd2, 1, 0, 0, 8'hFF, 8'h02, 8'hFC, 1, 0, 0);
      run_op("shl_sneg_sat",3'd2, 1, 0, 1, 8'hC0, 8'h02, 8'h80, 1, 1, 0);
      run_op("shl_big",     3'd2, 0, 0, 0, 8'h01, 8'h08, 8'h00, 0, 1, 0);
      run_op("shl_big_sat", 3'd2, 0, 0, 1, 8'h01, 8'h08, 8'hFF, 0, 1, 0);
      run_op("mix",         3'd5, 1, 1, 1, 8'hAB, 8'hCD, 8'hAD, 0, 0, 0);
      run_op("ill6",        3'd6, 1, 1, 1, 8'h7F, 8'h01, 8'h00, 0, 0, 1);
      run_op("ill7",        3'd7, 0, 0, 0, 8'h12, 8'h34, 8'h00, 0, 0, 1);

      // Ready stays high with an empty output stage even when the consumer is not ready
      out_ready = 1'b0;
      #1;
      chk("idle.rdy", in_ready, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Stream of 4 ops with a 3-cycle consumer stall
      drive(3'd0, 0, 0, 0, 8'h01, 8'h02);
      @(posedge clk); #1;
      drive(3'd0, 0, 0, 0, 8'h10, 8'h20);
      @(posedge clk); #1;
      chk("strm.v0", out_valid, 1);
      chk("strm.d0", out_data, 8'h03);
      drive(3'd0, 0, 0, 0, 8'h7F, 8'h7F);
      out_ready = 1'b0;
      #1;
      chk("strm.rdy_lo", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("strm.hold_v", out_valid, 1);
         chk("strm.hold_d", out_data, 8'h03);
         chk("strm.hold_rdy", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("strm.d1", out_data, 8'h30);
      drive(3'd1, 0, 0, 0, 8'h05, 8'h03);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("strm.d2", out_data, 8'hFE);
      @(posedge clk); #1;
      chk("strm.v3", out_valid, 1);
      chk("strm.d3", out_data, 8'h02);
      @(posedge clk); #1;
      chk("strm.drain", out_valid, 0);

      // Saturating overflow counter
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      chk("cnt.clr", ovf_cnt, 0);
      for (int i = 0; i < 5; i++) begin
         run_op("cnt.op", 3'd0, 1, 1, 0, 8'h7F, 8'h01, 8'h80, 1, 1, 0);
      end
      chk("cnt.sat", ovf_cnt, 3);

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      drive(3'd0, 1, 1, 0, 8'h7F, 8'h01);
      @(posedge clk); #1;
      drive(3'd2, 0, 0, 0, 8'h01, 8'h08);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("arst.pre_v", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("arst.vld", out_valid, 0);
      chk("arst.cnt", ovf_cnt, 0);
      chk("arst.data", out_data, 8'h00);
      chk("arst.ovf", out_ovf, 0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("arst.flushed", out_valid, 0);
      end
      run_op("post_rst", 3'd0, 0, 0, 0, 8'h11, 8'h22, 8'h33, 0, 0, 0);

      // Clear coincident with an overflow handshake
      run_op("clr.pre", 3'd1, 0, 0, 0, 8'h00, 8'h01, 8'hFF, 0, 1, 0);
      chk("clr.one", ovf_cnt, 1);
      drive(3'd1, 0, 0, 0, 8'h00, 8'h01);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("clr.vld", out_valid, 1);
      chk("clr.ovf", out_ovf, 1);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      chk("clr.wins", ovf_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
